// File: rtl/pcs_lane_skew_channel.sv
// Loopback channel emulator: per-lane block skew through circular delay buffers,
// plus periodic sync-header corruption on selected lanes.
module pcs_lane_skew_channel #(
    parameter int N_LANES       = 20,
    parameter int NB_DATA       = 66,
    parameter int MAX_SKEW      = 16,
    parameter int NB_SKEW       = $clog2(MAX_SKEW),
    parameter int NB_ERR_PERIOD = 16,
    parameter int NB_ERR_COUNT  = 32
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_valid,
    input  logic [N_LANES*NB_DATA-1:0]   i_data,
    input  logic [N_LANES*NB_SKEW-1:0]   i_rf_lane_skew,
    input  logic                         i_rf_skew_load,
    input  logic                         i_rf_enable_err,
    input  logic [N_LANES-1:0]           i_rf_err_lane_mask,
    input  logic [NB_ERR_PERIOD-1:0]     i_rf_err_period,
    output logic [N_LANES*NB_DATA-1:0]   o_data,
    output logic                         o_valid,
    output logic                         o_skew_busy,
    output logic [NB_ERR_COUNT-1:0]      o_err_count
);

    localparam logic [NB_SKEW-1:0] FILL_MAX = NB_SKEW'(MAX_SKEW - 1);

    logic                        adv;
    logic [NB_DATA-1:0]          mem [N_LANES][MAX_SKEW];
    logic [NB_SKEW-1:0]          wr_ptr;
    logic [NB_SKEW-1:0]          fill_cnt;
    logic [NB_SKEW-1:0]          skew [N_LANES];
    logic [NB_ERR_PERIOD-1:0]    err_cnt;
    logic [NB_ERR_PERIOD-1:0]    period_last;
    logic                        period_nz;
    logic                        inject;
    logic [N_LANES*NB_DATA-1:0]  data_next;

    assign adv         = i_valid & i_enable;
    assign period_nz   = (i_rf_err_period != '0);
    assign period_last = i_rf_err_period - NB_ERR_PERIOD'(1);
    assign inject      = adv & i_rf_enable_err & period_nz & (err_cnt == period_last);
    assign o_skew_busy = (fill_cnt != FILL_MAX);

    // Read happens before this cycle's write lands, so d = MAX_SKEW-1 never collides.
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic [NB_SKEW-1:0] rd_idx;
        logic [NB_DATA-1:0] sel;

        assign rd_idx = wr_ptr - skew[k];

        always_comb begin
            if (skew[k] == '0) begin
                sel = i_data[k*NB_DATA +: NB_DATA];
            end else if (skew[k] <= fill_cnt) begin
                sel = mem[k][rd_idx];
            end else begin
                sel = '0;
            end
            if (inject && i_rf_err_lane_mask[k]) begin
                sel[NB_DATA-1 -: 2] = 2'b11;
            end
        end

        assign data_next[k*NB_DATA +: NB_DATA] = sel;
    end

    // Buffer contents are intentionally left unreset; fill_cnt gates stale entries.
    always_ff @(posedge i_clock) begin
        if (adv) begin
            for (int k = 0; k < N_LANES; k++) begin
                mem[k][wr_ptr] <= i_data[k*NB_DATA +: NB_DATA];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                skew[k] <= '0;
            end
        end else begin
            if (adv) begin
                wr_ptr <= (wr_ptr == FILL_MAX) ? '0 : wr_ptr + NB_SKEW'(1);
            end
            if (i_rf_skew_load) begin
                fill_cnt <= '0;
                for (int k = 0; k < N_LANES; k++) begin
                    skew[k] <= i_rf_lane_skew[k*NB_SKEW +: NB_SKEW];
                end
            end else if (adv && fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + NB_SKEW'(1);
            end
        end
    end

    // A shrunk period restarts the count rather than running up to wrap.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            err_cnt     <= '0;
            o_err_count <= '0;
        end else begin
            if (!i_rf_enable_err || !period_nz) begin
                err_cnt <= '0;
            end else if (adv) begin
                err_cnt <= (err_cnt >= period_last) ? '0 : err_cnt + NB_ERR_PERIOD'(1);
            end
            if (inject && o_err_count != '1) begin
                o_err_count <= o_err_count + NB_ERR_COUNT'(1);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= adv;
            if (adv) begin
                o_data <= data_next;
            end
        end
    end

endmodule

// File: tb/tb_pcs_lane_skew_channel.sv
// Directed bench for pcs_lane_skew_channel: expected blocks are queued at stimulus
// time and a negedge monitor pops and compares them whenever o_valid is high.
module tb_pcs_lane_skew_channel;

    localparam int NL = 20;
    localparam int NB = 66;
    localparam int NS = 4;
    localparam int W  = NL * NB;

    typedef struct {
        logic [W-1:0] data;
        logic         busy;
        logic [31:0]  errc;
    } exp_t;

    logic            clk = 1'b0;
    logic            i_reset;
    logic            i_enable;
    logic            i_valid;
    logic [W-1:0]    i_data;
    logic [NL*NS-1:0] i_rf_lane_skew;
    logic            i_rf_skew_load;
    logic            i_rf_enable_err;
    logic [NL-1:0]   i_rf_err_lane_mask;
    logic [15:0]     i_rf_err_period;
    logic [W-1:0]    o_data;
    logic            o_valid;
    logic            o_skew_busy;
    logic [31:0]     o_err_count;

    int           vectors = 0;
    int           miscompares = 0;
    exp_t         q[$];
    exp_t         cur;
    logic         hold_chk = 1'b0;
    logic [W-1:0] last_data = '0;

    always #5 clk = ~clk;

    pcs_lane_skew_channel dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_enable           (i_enable),
        .i_valid            (i_valid),
        .i_data             (i_data),
        .i_rf_lane_skew     (i_rf_lane_skew),
        .i_rf_skew_load     (i_rf_skew_load),
        .i_rf_enable_err    (i_rf_enable_err),
        .i_rf_err_lane_mask (i_rf_err_lane_mask),
        .i_rf_err_period    (i_rf_err_period),
        .o_data             (o_data),
        .o_valid            (o_valid),
        .o_skew_busy        (o_skew_busy),
        .o_err_count        (o_err_count)
    );

    function automatic logic [NB-1:0] blk(int lane, int seq);
        return {2'b01, 8'(lane), 16'(seq), 40'h5AC30F96E1};
    endfunction

    function automatic logic [W-1:0] make_vec(int seq);
        logic [W-1:0] v;
        for (int k = 0; k < NL; k++) v[k*NB +: NB] = blk(k, seq);
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        logic [31:0]  r = 32'd0;
        for (int i = 0; i < W; i++) begin
            if (i % 32 == 0) r = $urandom;
            v[i] = r[i % 32];
        end
        return v;
    endfunction

    task automatic cmp_data(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            for (int k = 0; k < NL; k++) begin
                if (got[k*NB +: NB] !== want[k*NB +: NB]) begin
                    $display("FAIL %s lane %0d: got %h want %h", name, k, got[k*NB +: NB], want[k*NB +: NB]);
                    break;
                end
            end
        end
    endtask

    task automatic cmp_val(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        cmp_data({tag, "_data"}, o_data, '0);
        cmp_val({tag, "_valid"}, 32'(o_valid), 32'd0);
        cmp_val({tag, "_busy"}, 32'(o_skew_busy), 32'd1);
        cmp_val({tag, "_errc"}, o_err_count, 32'd0);
    endtask

    task automatic push(input logic [W-1:0] d, input logic b, input int ec);
        exp_t x;
        x.data = d;
        x.busy = b;
        x.errc = 32'(ec);
        q.push_back(x);
    endtask

    task automatic step(input logic v, input logic ld, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        i_valid        = v;
        i_rf_skew_load = ld;
        i_data         = d;
    endtask

    always @(negedge clk) begin
        if (i_reset) begin
            if (o_valid) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: got o_valid 1 want no pending block");
                end else begin
                    cur = q.pop_front();
                    cmp_data("data", o_data, cur.data);
                    cmp_val("busy", 32'(o_skew_busy), 32'(cur.busy));
                    cmp_val("err_count", o_err_count, cur.errc);
                    last_data = cur.data;
                end
            end else if (hold_chk) begin
                cmp_data("hold", o_data, last_data);
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] e;
        int d;

        i_reset = 1'b0;
        i_enable = 1'b1;
        i_valid = 1'b0;
        i_data = '0;
        i_rf_lane_skew = '0;
        i_rf_skew_load = 1'b0;
        i_rf_enable_err = 1'b0;
        i_rf_err_lane_mask = '0;
        i_rf_err_period = '0;
        #1;
        chk_reset("por");
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b1;

        // zero skew: one clock of latency
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 1'b0, make_vec(n));
            push(make_vec(n), 1'b1, 0);
        end
        step(1'b0, 1'b0, rnd_vec());

        // reset asserted while output still valid
        @(negedge clk);
        #1;
        i_valid = 1'b1;
        i_data  = rnd_vec();
        i_reset = 1'b0;
        #1;
        chk_reset("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        chk_reset("rel");
        for (int n = 10; n < 14; n++) begin
            step(1'b1, 1'b0, make_vec(n));
            push(make_vec(n), 1'b1, 0);
        end

        // per-lane skew k mod 16
        for (int k = 0; k < NL; k++) i_rf_lane_skew[k*NS +: NS] = 4'(k % 16);
        step(1'b0, 1'b1, rnd_vec());
        for (int n = 0; n < 64; n++) begin
            v = make_vec(1000 + n);
            for (int k = 0; k < NL; k++) begin
                d = k % 16;
                e[k*NB +: NB] = (n >= d) ? blk(k, 1000 + n - d) : '0;
            end
            step(1'b1, 1'b0, v);
            push(e, (n + 1 < 15), 0);
        end

        // gapped valid, lane 3 skew 5
        i_rf_lane_skew = '0;
        i_rf_lane_skew[3*NS +: NS] = 4'd5;
        step(1'b0, 1'b1, rnd_vec());
        hold_chk = 1'b1;
        for (int n = 0; n < 12; n++) begin
            e = make_vec(300 + n);
            e[3*NB +: NB] = (n >= 5) ? blk(3, 300 + n - 5) : '0;
            step(1'b1, 1'b0, make_vec(300 + n));
            push(e, 1'b1, 0);
            repeat (39) step(1'b0, 1'b0, rnd_vec());
        end
        hold_chk = 1'b0;

        // load in the same cycle as a valid block; old skew still used for it
        for (int k = 0; k < NL; k++) i_rf_lane_skew[k*NS +: NS] = 4'd2;
        e = make_vec(400);
        e[3*NB +: NB] = blk(3, 307);
        step(1'b1, 1'b1, make_vec(400));
        push(e, 1'b1, 0);
        for (int j = 1; j <= 20; j++) begin
            for (int k = 0; k < NL; k++) e[k*NB +: NB] = (j >= 3) ? blk(k, 400 + j - 2) : '0;
            step(1'b1, 1'b0, make_vec(400 + j));
            push(e, (j < 15), 0);
        end

        // error injection, period 4 on lanes 0 and 2
        i_rf_lane_skew = '0;
        step(1'b0, 1'b1, rnd_vec());
        i_rf_err_period = 16'd4;
        i_rf_err_lane_mask = 20'h00005;
        i_rf_enable_err = 1'b1;
        for (int m = 1; m <= 20; m++) begin
            v = make_vec(500 + m);
            e = v;
            if (m % 4 == 0) begin
                e[0*NB + NB - 2 +: 2] = 2'b11;
                e[2*NB + NB - 2 +: 2] = 2'b11;
            end
            step(1'b1, 1'b0, v);
            push(e, (m < 15), m / 4);
        end

        // disabled: valid ignored, output holds
        step(1'b1, 1'b0, rnd_vec());
        i_enable = 1'b0;
        hold_chk = 1'b1;
        repeat (2) step(1'b1, 1'b0, rnd_vec());
        step(1'b0, 1'b0, rnd_vec());
        i_enable = 1'b1;
        i_rf_err_period = 16'd0;
        step(1'b0, 1'b0, rnd_vec());
        hold_chk = 1'b0;

        // period 0 stops injection
        for (int m = 21; m <= 24; m++) begin
            step(1'b1, 1'b0, make_vec(500 + m));
            push(make_vec(500 + m), 1'b0, 5);
        end
        step(1'b0, 1'b0, rnd_vec());

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending blocks want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
